rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised successor to the 16-entry fixed-format reorder buffer.
- Circular in-order retirement buffer between rename/dispatch and architectural register commit.
- Explicit allocate/writeback/commit handshakes; ROB index is the tag.
- Adds partial rollback (squash younger than a branch), configurable depth/data width and writeback port count.

Parameters:
- DEPTH, 16, entry count; power of two, ≥4.
- DATA_W, 16, result width.
- DEST_W, 5, architectural destination index width.
- TYPE_W, 2, instruction type field width.
- NUM_WB, 2, writeback ports, 1..4.
- IDX_W, $clog2(DEPTH), derived index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  2  per-lane allocate request; lane1 only valid if lane0 valid
- alloc_dest  in  2*DEST_W  per-lane destination
- alloc_type  in  2*TYPE_W  per-lane type
- alloc_ready  out  2  [0]=free≥1, [1]=free≥2
- alloc_idx  out  2*IDX_W  tail, tail+1 (combinational)
- wb_valid  in  NUM_WB  writeback strobes
- wb_idx  in  NUM_WB*IDX_W  target entry
- wb_data  in  NUM_WB*DATA_W  result
- commit_valid  out  2  head / head+1 valid and ready (lane1 needs lane0)
- commit_ready  in  2  consumer accepts lane
- commit_idx, commit_dest, commit_type, commit_data  out  2*IDX_W / 2*DEST_W / 2*TYPE_W / 2*DATA_W  head-entry fields
- rb_valid  in  1  rollback strobe
- rb_idx  in  IDX_W  last surviving entry
- flush  in  1  synchronous clear-all
- count  out  $clog2(DEPTH+1)  occupancy
- full, empty  out  1  count==DEPTH / count==0

Behaviour:
- Reset (async, rst_n low): all entries invalid, head=tail=0, count=0, empty=1, full=0, alloc_ready=2'b11, commit_valid=0. All other outputs 0.
- Entry fields: valid, ready, dest, type, data.
- Allocation: lane k fires on alloc_valid[k]&alloc_ready[k]. Entry written valid=1, ready=0, data=0. Tail advances by number fired. alloc_ready uses the pre-edge count; same-cycle commits do not free space for allocation.
- Writeback: on wb_valid[k] to a valid entry, set ready=1 and store wb_data. Writebacks to invalid entries are ignored. Two ports hitting the same index: higher port number wins. Writeback becomes visible on commit_valid the next cycle (no bypass).
- Commit: lane k retires on commit_valid[k]&commit_ready[k]. Lane1 retires only if lane0 retires. A retired entry is invalidated; head advances by the number retired. Outputs are combinational from registered state, so commit latency is 0 after ready is set.
- Count update: count_next = count + allocs − commits. Pointers wrap modulo DEPTH.
- Rollback (rb_valid with rb_idx a valid entry):
  - Entries strictly younger than rb_idx are invalidated; tail <= rb_idx+1.
  - Same-cycle allocation is suppressed; same-cycle commits and writebacks to surviving entries proceed.
  - count_next = ((rb_idx − head) mod DEPTH) + 1 − commits.
  - If rb_idx is invalid, or its entry retires this cycle, rollback is ignored.
- flush: highest priority below reset. Same effect as reset, taken on the clock edge. Overrides alloc, wb, commit and rollback.
- Full: with count==DEPTH, alloc_ready=0 and tail==head.
- Priority: rst_n > flush > rollback > alloc.

Optional Feature:
- Macro ROB_EXC_EN.
- When defined:
  - Adds input wb_exc[NUM_WB], stored per entry.
  - Adds output commit_exc[2].
  - An excepting entry at head commits on lane0 only; lane1 is blocked.
  - After it retires, the ROB auto-flushes the next cycle.
- When undefined: no exception storage; ports are absent.

Decomposition:
- Package rob_pkg holds:
  - Entry struct typedef rob_entry_t (parametrised via localparams in the module).
  - Lane count constant ROB_LANES=2.
  - Index-distance function rob_dist(a,b).
- Sub-module rob_wb_mux: per-entry writeback select across NUM_WB ports with priority resolution.

Test Plan:
- Reset, alloc 2 entries (dest 3,7), wb idx1 data 0xBEEF then idx0 data 0x1234 -> commit_valid=2'b11 same cycle; commits idx0/0x1234 then idx1/0xBEEF; empty=1.
- Fill DEPTH=16 via 8 dual allocs -> full=1, alloc_ready=0. Commit 1, wb nothing -> alloc_ready[0]=1, [1]=0.
- Pointer wrap: alloc/commit 20 entries one per cycle -> alloc_idx sequence 0..15,0..3; count never >1.
- Rollback: head=2, tail=9, rb_idx=4 -> entries 5..8 invalid, tail=5, count=3. A same-cycle alloc is dropped.
- Simultaneous wb ports 0 and 1 to idx 6 with 0xAAAA/0x5555 -> stored 0x5555. wb to invalid idx 12 -> no state change.
- flush mid-stream with 10 entries plus commit_ready high -> no commit recorded, count=0. Async rst_n pulse mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared constants and helpers for the parametrised reorder buffer.
// Declarations only; adds no latency.
// No flow control of its own; consumed by rob_param and rob_wb_mux.
package rob_pkg;

  // Allocate and commit are both two lanes wide.
  localparam int ROB_LANES = 2;

  // Forward distance from a to b on a ring of depth entries (depth is a power of two).
  function automatic int unsigned rob_dist(input int unsigned a, input int unsigned b,
                                           input int unsigned depth);
    return (b + depth - a) & (depth - 1);
  endfunction

endpackage

// File: rtl/rob_wb_mux.sv
// Writeback select for one ROB entry across all writeback ports.
// Purely combinational, zero latency; the highest-numbered matching port wins.
// No backpressure: writebacks are always accepted, or dropped by the caller if the entry is invalid.
module rob_wb_mux
  import rob_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16,
  parameter int NUM_WB = 2,
  parameter int ENTRY  = 0
) (
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]  wb_idx,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
`ifdef ROB_EXC_EN
  input  logic [NUM_WB-1:0]        wb_exc,
  output logic                     hit_exc,
`endif
  output logic                     hit,
  output logic [DATA_W-1:0]        hit_data
);

  // Scan ports low to high so a later (higher) port overrides an earlier match.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
`ifdef ROB_EXC_EN
    hit_exc  = 1'b0;
`endif
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_idx[k*IDX_W +: IDX_W] == IDX_W'(ENTRY))) begin
        hit      = 1'b1;
        hit_data = wb_data[k*DATA_W +: DATA_W];
`ifdef ROB_EXC_EN
        hit_exc  = wb_exc[k];
`endif
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Circular two-lane reorder buffer with writeback, in-order commit, partial rollback and flush.
// Commit outputs are combinational from state: an entry can retire the cycle after its writeback.
// Allocation stalls via alloc_ready on pre-edge occupancy; commit waits on commit_ready per lane.
// Optional exception tracking is enabled by defining ROB_EXC_EN.
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int DEST_W = 5,
  parameter int TYPE_W = 2,
  parameter int NUM_WB = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ROB_LANES-1:0]           alloc_valid,
  input  logic [ROB_LANES*DEST_W-1:0]    alloc_dest,
  input  logic [ROB_LANES*TYPE_W-1:0]    alloc_type,
  output logic [ROB_LANES-1:0]           alloc_ready,
  output logic [ROB_LANES*IDX_W-1:0]     alloc_idx,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]        wb_idx,
  input  logic [NUM_WB*DATA_W-1:0]       wb_data,
`ifdef ROB_EXC_EN
  input  logic [NUM_WB-1:0]              wb_exc,
  output logic [ROB_LANES-1:0]           commit_exc,
`endif
  output logic [ROB_LANES-1:0]           commit_valid,
  input  logic [ROB_LANES-1:0]           commit_ready,
  output logic [ROB_LANES*IDX_W-1:0]     commit_idx,
  output logic [ROB_LANES*DEST_W-1:0]    commit_dest,
  output logic [ROB_LANES*TYPE_W-1:0]    commit_type,
  output logic [ROB_LANES*DATA_W-1:0]    commit_data,
  input  logic                           rb_valid,
  input  logic [IDX_W-1:0]               rb_idx,
  input  logic                           flush,
  output logic [CNT_W-1:0]               count,
  output logic                           full,
  output logic                           empty
);

  typedef struct packed {
    logic              vld;
    logic              rdy;
`ifdef ROB_EXC_EN
    logic              exc;
`endif
    logic [DEST_W-1:0] dest;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] dat;
  } rob_entry_t;

  rob_entry_t        ent_q [DEPTH];
  rob_entry_t        ent_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  lane_ptr  [ROB_LANES];
  logic [IDX_W-1:0]  alloc_ptr [ROB_LANES];
  logic [DEPTH-1:0]  wb_hit;
  logic [DATA_W-1:0] wb_hit_dat [DEPTH];
  logic [ROB_LANES-1:0] cv, retire, fire, ar;
  logic [CNT_W-1:0]  n_ret, n_fire;
  logic [IDX_W-1:0]  rb_span;
  logic              rb_hit, clear_all, head_exc;
`ifdef ROB_EXC_EN
  logic [DEPTH-1:0]  wb_hit_exc;
  logic              exc_flush_q, exc_flush_d;
`endif

  assign lane_ptr[0]  = head_q;
  assign lane_ptr[1]  = head_q + IDX_W'(1);
  assign alloc_ptr[0] = tail_q;
  assign alloc_ptr[1] = tail_q + IDX_W'(1);

  for (genvar g = 0; g < DEPTH; g++) begin : g_wb
    rob_wb_mux #(.IDX_W(IDX_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB), .ENTRY(g)) u_wb_mux (
      .wb_valid (wb_valid),
      .wb_idx   (wb_idx),
      .wb_data  (wb_data),
`ifdef ROB_EXC_EN
      .wb_exc   (wb_exc),
      .hit_exc  (wb_hit_exc[g]),
`endif
      .hit      (wb_hit[g]),
      .hit_data (wb_hit_dat[g])
    );
  end

  // Handshake qualification: commit lanes, allocation lanes and whether a rollback takes effect.
  always_comb begin
    clear_all = flush;
    head_exc  = 1'b0;
`ifdef ROB_EXC_EN
    clear_all = flush | exc_flush_q;
    head_exc  = ent_q[head_q].exc;
`endif
    // A clearing cycle never shows a commit handshake, so the consumer records nothing.
    cv[0]     = ent_q[lane_ptr[0]].vld & ent_q[lane_ptr[0]].rdy & ~clear_all;
    cv[1]     = cv[0] & ent_q[lane_ptr[1]].vld & ent_q[lane_ptr[1]].rdy & ~head_exc;
    retire[0] = cv[0] & commit_ready[0];
    retire[1] = retire[0] & cv[1] & commit_ready[1];
    n_ret     = CNT_W'(retire[0]) + CNT_W'(retire[1]);
    // Space is judged on pre-edge occupancy; same-cycle commits do not help.
    ar[0]     = count_q < CNT_W'(DEPTH);
    ar[1]     = count_q < CNT_W'(DEPTH - 1);
`ifdef ROB_EXC_EN
    ar        = ar & ~{ROB_LANES{exc_flush_q}};
`endif
    rb_span   = IDX_W'(rob_dist(32'(head_q), 32'(rb_idx), unsigned'(DEPTH)));
    rb_hit    = rb_valid & ent_q[rb_idx].vld
              & ~(retire[0] & (rb_idx == lane_ptr[0]))
              & ~(retire[1] & (rb_idx == lane_ptr[1]));
    fire[0]   = alloc_valid[0] & ar[0] & ~rb_hit;
    fire[1]   = fire[0] & alloc_valid[1] & ar[1] & ~rb_hit;
    n_fire    = CNT_W'(fire[0]) + CNT_W'(fire[1]);
  end

  // Next state: writeback, then rollback squash, retire, allocate; a clear overrides all of it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].vld && wb_hit[i]) begin
        ent_d[i].rdy = 1'b1;
        ent_d[i].dat = wb_hit_dat[i];
`ifdef ROB_EXC_EN
        ent_d[i].exc = wb_hit_exc[i];
`endif
      end
      if (rb_hit && ent_q[i].vld &&
          (IDX_W'(rob_dist(32'(head_q), unsigned'(i), unsigned'(DEPTH))) > rb_span)) begin
        ent_d[i] = '0;
      end
    end
    for (int l = 0; l < ROB_LANES; l++) begin
      if (retire[l]) ent_d[lane_ptr[l]] = '0;
    end
    for (int l = 0; l < ROB_LANES; l++) begin
      if (fire[l]) begin
        ent_d[alloc_ptr[l]]      = '0;
        ent_d[alloc_ptr[l]].vld  = 1'b1;
        ent_d[alloc_ptr[l]].dest = alloc_dest[l*DEST_W +: DEST_W];
        ent_d[alloc_ptr[l]].typ  = alloc_type[l*TYPE_W +: TYPE_W];
      end
    end
    head_d  = head_q + IDX_W'(n_ret);
    tail_d  = rb_hit ? rb_idx + IDX_W'(1) : tail_q + IDX_W'(n_fire);
    count_d = rb_hit ? CNT_W'(rb_span) + CNT_W'(1) - n_ret : count_q + n_fire - n_ret;
`ifdef ROB_EXC_EN
    // An excepting head that retires schedules a full clear for the following cycle.
    exc_flush_d = retire[0] & head_exc;
`endif
    if (clear_all) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
`ifdef ROB_EXC_EN
      exc_flush_d = 1'b0;
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
`ifdef ROB_EXC_EN
      exc_flush_q <= 1'b0;
`endif
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
`ifdef ROB_EXC_EN
      exc_flush_q <= exc_flush_d;
`endif
    end
  end

  // Commit field view: fields of a lane read zero unless that lane is valid.
  always_comb begin
    commit_idx  = '0;
    commit_dest = '0;
    commit_type = '0;
    commit_data = '0;
`ifdef ROB_EXC_EN
    commit_exc  = '0;
`endif
    for (int l = 0; l < ROB_LANES; l++) begin
      if (cv[l]) begin
        commit_idx[l*IDX_W +: IDX_W]    = lane_ptr[l];
        commit_dest[l*DEST_W +: DEST_W] = ent_q[lane_ptr[l]].dest;
        commit_type[l*TYPE_W +: TYPE_W] = ent_q[lane_ptr[l]].typ;
        commit_data[l*DATA_W +: DATA_W] = ent_q[lane_ptr[l]].dat;
`ifdef ROB_EXC_EN
        commit_exc[l]                   = ent_q[lane_ptr[l]].exc;
`endif
      end
    end
  end

  assign commit_valid = cv;
  assign alloc_ready  = ar;
  assign alloc_idx    = {alloc_ptr[1], alloc_ptr[0]};
  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: scoreboard of allocated entries, checked as lanes commit.
// Inputs change 2 time units after posedge; commits are observed at negedge.
// Expected commit order/data come from the bench's own allocation and writeback record.
module tb_rob_param;
  localparam int DEPTH = 16, DATA_W = 16, DEST_W = 5, TYPE_W = 2, NUM_WB = 2;
  localparam int IDX_W = 4, CNT_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]               alloc_valid = '0;
  logic [2*DEST_W-1:0]      alloc_dest = '0;
  logic [2*TYPE_W-1:0]      alloc_type = '0;
  logic [1:0]               alloc_ready;
  logic [2*IDX_W-1:0]       alloc_idx;
  logic [NUM_WB-1:0]        wb_valid = '0;
  logic [NUM_WB*IDX_W-1:0]  wb_idx = '0;
  logic [NUM_WB*DATA_W-1:0] wb_data = '0;
  logic [1:0]               commit_valid;
  logic [1:0]               commit_ready = '0;
  logic [2*IDX_W-1:0]       commit_idx;
  logic [2*DEST_W-1:0]      commit_dest;
  logic [2*TYPE_W-1:0]      commit_type;
  logic [2*DATA_W-1:0]      commit_data;
  logic                     rb_valid = 1'b0;
  logic [IDX_W-1:0]         rb_idx = '0;
  logic                     flush = 1'b0;
  logic [CNT_W-1:0]         count;
  logic                     full, empty;

  always #5 clk = ~clk;

  rob_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DEST_W(DEST_W), .TYPE_W(TYPE_W),
              .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_type(alloc_type),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_idx(commit_idx),
    .commit_dest(commit_dest), .commit_type(commit_type), .commit_data(commit_data),
    .rb_valid(rb_valid), .rb_idx(rb_idx), .flush(flush),
    .count(count), .full(full), .empty(empty)
  );

  int checks = 0, errors = 0, n_commit = 0, saved = 0, m_tail = 0, mon_e = 0;
  int sb_q[$];
  int m_dest [DEPTH];
  int m_type [DEPTH];
  int m_data [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alloc_valid = '0; wb_valid = '0; commit_ready = '0; rb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic go();
    tick();
    idle();
  endtask

  task automatic push(input int idx, input int d);
    sb_q.push_back(idx);
    m_dest[idx] = d; m_type[idx] = d % 4; m_data[idx] = 0;
  endtask

  task automatic alloc(input int n, input int d0, input int d1);
    check("alloc_idx", alloc_idx[IDX_W-1:0], m_tail);
    alloc_valid = (n == 2) ? 2'b11 : 2'b01;
    alloc_dest  = {DEST_W'(d1), DEST_W'(d0)};
    alloc_type  = {TYPE_W'(d1), TYPE_W'(d0)};
    push(m_tail, d0);
    if (n == 2) push((m_tail + 1) % DEPTH, d1);
    m_tail = (m_tail + n) % DEPTH;
    go();
  endtask

  // Drive one writeback port (no clock); live means the bench expects the entry to hold it.
  task automatic wb(input int p, input int idx, input int d, input bit live);
    wb_valid[p] = 1'b1;
    wb_idx[p*IDX_W +: IDX_W]   = IDX_W'(idx);
    wb_data[p*DATA_W +: DATA_W] = DATA_W'(d);
    if (live) m_data[idx] = d;
  endtask

  task automatic commit(input logic [1:0] cr, input int n);
    commit_ready = cr;
    repeat (n) tick();
    idle();
  endtask

  // Commit monitor: every lane handshake must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < 2; l++) begin
        if (commit_valid[l] && commit_ready[l] &&
            (l == 0 || (commit_valid[0] && commit_ready[0]))) begin
          n_commit++;
          check("commit_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("commit_idx",  commit_idx[l*IDX_W +: IDX_W],    mon_e);
            check("commit_dest", commit_dest[l*DEST_W +: DEST_W], m_dest[mon_e]);
            check("commit_type", commit_type[l*TYPE_W +: TYPE_W], m_type[mon_e]);
            check("commit_data", commit_data[l*DATA_W +: DATA_W], m_data[mon_e]);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_alloc_ready", alloc_ready, 2'b11);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_alloc_idx", alloc_idx, 8'h10);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Basic alloc / out-of-order writeback / in-order commit
    alloc(2, 3, 7);
    check("basic_count", count, 2);
    check("basic_cv_none", commit_valid, 0);
    wb(0, 1, 16'hBEEF, 1); go();
    check("basic_cv_head_not_ready", commit_valid, 0);
    wb(0, 0, 16'h1234, 1); go();
    check("basic_cv_both", commit_valid, 2'b11);
    check("basic_data_both", commit_data, 32'hBEEF_1234);
    commit(2'b01, 1);
    commit(2'b01, 1);
    check("basic_empty", empty, 1);

    // Fill to full, free one slot, refill, drain
    for (int k = 0; k < 8; k++) alloc(2, 2 * k, 2 * k + 1);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_alloc_ready", alloc_ready, 2'b00);
    wb(0, 2, 16'h1000, 1); go();
    commit(2'b01, 1);
    check("fill_ready_one", alloc_ready, 2'b01);
    check("fill_count_15", count, 15);
    alloc(1, 20, 0);
    check("refill_full", full, 1);
    for (int k = 0; k < 8; k++) begin
      wb(0, 2 * k, 16'h2000 + 2 * k, 1);
      wb(1, 2 * k + 1, 16'h2001 + 2 * k, 1);
      go();
    end
    commit(2'b11, 8);
    check("drain_empty", empty, 1);

    // Flush with ten entries and a ready consumer
    for (int k = 0; k < 5; k++) alloc(2, k + 1, k + 10);
    wb(0, 3, 16'h0303, 1); wb(1, 4, 16'h0404, 1); go();
    check("flush_cv_before", commit_valid, 2'b11);
    saved = n_commit;
    flush = 1'b1; commit_ready = 2'b11;
    go();
    check("flush_no_commit", n_commit, saved);
    check("flush_count", count, 0);
    check("flush_alloc_idx", alloc_idx[IDX_W-1:0], 0);
    check("flush_cv_after", commit_valid, 0);
    sb_q.delete();
    m_tail = 0;

    // Pointer wrap, one entry in flight at a time
    for (int i = 0; i < 20; i++) begin
      check("wrap_idx", alloc_idx[IDX_W-1:0], i % 16);
      alloc(1, i, 0);
      check("wrap_cnt_alloc", count, 1);
      wb(1, i % 16, 16'h3000 + i, 1); go();
      commit(2'b01, 1);
      check("wrap_cnt_drain", count, 0);
    end

    // Rollback: head=2, tail=9, keep through idx 4
    flush = 1'b1; go();
    m_tail = 0;
    alloc(2, 1, 2);
    wb(0, 0, 16'h0A00, 1); wb(1, 1, 16'h0A01, 1); go();
    commit(2'b11, 1);
    alloc(2, 3, 4); alloc(2, 5, 6); alloc(2, 7, 8); alloc(1, 9, 0);
    check("rb_count_before", count, 7);
    rb_valid = 1'b1; rb_idx = 4'd4;
    alloc_valid = 2'b01; alloc_dest = DEST_W'(9) ; alloc_type = '0;
    go();
    repeat (4) void'(sb_q.pop_back());
    m_tail = 5;
    check("rb_count", count, 3);
    check("rb_tail", alloc_idx[IDX_W-1:0], 5);
    wb(0, 6, 16'h7777, 0); go();
    check("rb_wb_squashed", count, 3);
    alloc(1, 11, 0);
    wb(0, 2, 16'h4002, 1); wb(1, 3, 16'h4003, 1); go();
    wb(0, 4, 16'h4004, 1); go();
    commit(2'b11, 2);
    check("rb_partial_count", count, 1);
    check("rb_partial_cv", commit_valid, 0);

    // Same-index writeback on both ports; writeback to an invalid entry
    alloc(1, 12, 0);
    wb(0, 6, 16'hAAAA, 1); wb(1, 6, 16'h5555, 1); go();
    wb(0, 5, 16'h0555, 1); wb(1, 12, 16'hDEAD, 0); go();
    check("wb_count", count, 2);
    check("wb_cv", commit_valid, 2'b11);
    check("wb_port_prio", commit_data[31:16], 16'h5555);
    commit(2'b11, 1);
    check("wb_empty", empty, 1);

    // Asynchronous reset pulse mid-cycle
    alloc(2, 1, 2);
    wb(0, 7, 16'h0707, 1); wb(1, 8, 16'h0808, 1); go();
    check("arst_cv_before", commit_valid, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_cv", commit_valid, 0);
    check("arst_data", commit_data, 0);
    check("arst_empty", empty, 1);
    check("arst_alloc_ready", alloc_ready, 2'b11);
    rst_n = 1'b1;
    sb_q.delete();
    m_tail = 0;
    go();

    // Rollback to an invalid index is ignored and does not block allocation
    alloc(2, 1, 2);
    rb_valid = 1'b1; rb_idx = 4'd5;
    alloc(1, 3, 0);
    check("rb_ign_count", count, 3);
    check("rb_ign_tail", alloc_idx[IDX_W-1:0], 3);
    wb(0, 0, 16'h0B00, 1); wb(1, 1, 16'h0B01, 1); go();
    wb(0, 2, 16'h0B02, 1); go();
    commit(2'b11, 2);
    check("final_empty", empty, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
